pwm_regs_mc: RTL and testbench



---
 rtl/pwm_regs_mc.sv | 243 ++++++++++++++++++++++++
 tb/tb_pwm_regs_mc.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_regs_mc.sv
// pwm_regs_mc: multi-channel PWM register bank.
// Each channel owns a pwm_regs_ch instance holding its staging bytes,
// committed timing registers, counter snapshot and count_reset pulse.
// Optional feature macro: PWM_REGS_SHADOW_EN. When it is defined, the
// period, compare1, compare2 and functions commits land in a buffer.
// The buffer moves to the active outputs on that channel's update_evt,
// or on a software force through offset 0xE.

module pwm_regs_ch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  off,
  input  logic [7:0]  wd,
  input  logic [15:0] cnt,
  input  logic        upd_evt,
  output logic [7:0]  rd,
  output logic [15:0] period,
  output logic [15:0] compare1,
  output logic [15:0] compare2,
  output logic [7:0]  functions,
  output logic [7:0]  prescale,
  output logic        en,
  output logic        upnotdown,
  output logic        pwm_en,
  output logic        count_reset
);

  logic [7:0]  per_stg, c1_stg, c2_stg, snap_hi;
  logic [15:0] per_view, c1_view, c2_view;
  logic [7:0]  fn_view;
  logic        pending;
  logic        wr_per, wr_c1, wr_c2, wr_fn;

  // An H write commits {H byte, staged L byte} in one cycle.
  assign wr_per = we && (off == 4'h1);
  assign wr_c1  = we && (off == 4'h4);
  assign wr_c2  = we && (off == 4'h6);
  assign wr_fn  = we && (off == 4'hD);

  // Staging bytes, immediate byte-wide registers, counter snapshot, count_reset pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_stg     <= '0;
      c1_stg      <= '0;
      c2_stg      <= '0;
      snap_hi     <= '0;
      prescale    <= '0;
      en          <= 1'b0;
      upnotdown   <= 1'b0;
      pwm_en      <= 1'b0;
      count_reset <= 1'b0;
    end else begin
      count_reset <= we && (off == 4'h7) && wd[0];
      if (we) begin
        case (off)
          4'h0:    per_stg   <= wd;
          4'h2:    en        <= wd[0];
          4'h3:    c1_stg    <= wd;
          4'h5:    c2_stg    <= wd;
          4'hA:    prescale  <= wd;
          4'hB:    upnotdown <= wd[0];
          4'hC:    pwm_en    <= wd[0];
          default: ;
        endcase
      end
      // The high byte is frozen when the low byte is read, so an L/H read pair is coherent
      if (re && (off == 4'h8)) snap_hi <= cnt[15:8];
    end
  end

`ifdef PWM_REGS_SHADOW_EN
  logic [15:0] per_buf, c1_buf, c2_buf;
  logic [7:0]  fn_buf;
  logic        commit, load;

  assign commit = wr_per | wr_c1 | wr_c2 | wr_fn;
  // A transfer happens on a period boundary with work pending, or on a software force
  assign load   = (upd_evt && pending) || (we && (off == 4'hE) && wd[0]);

  // Buffer takes commits; active takes the pre-edge buffer on load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_buf   <= '0;
      c1_buf    <= '0;
      c2_buf    <= '0;
      fn_buf    <= '0;
      period    <= '0;
      compare1  <= '0;
      compare2  <= '0;
      functions <= '0;
      pending   <= 1'b0;
    end else begin
      if (wr_per) per_buf <= {wd, per_stg};
      if (wr_c1)  c1_buf  <= {wd, c1_stg};
      if (wr_c2)  c2_buf  <= {wd, c2_stg};
      if (wr_fn)  fn_buf  <= wd;
      if (load) begin
        period    <= per_buf;
        compare1  <= c1_buf;
        compare2  <= c2_buf;
        functions <= fn_buf;
      end
      // A commit colliding with a load leaves the new value pending
      if (commit)    pending <= 1'b1;
      else if (load) pending <= 1'b0;
    end
  end

  assign per_view = per_buf;
  assign c1_view  = c1_buf;
  assign c2_view  = c2_buf;
  assign fn_view  = fn_buf;
`else
  logic unused_upd;
  assign unused_upd = upd_evt;

  // Commits drive the active outputs directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period    <= '0;
      compare1  <= '0;
      compare2  <= '0;
      functions <= '0;
    end else begin
      if (wr_per) period    <= {wd, per_stg};
      if (wr_c1)  compare1  <= {wd, c1_stg};
      if (wr_c2)  compare2  <= {wd, c2_stg};
      if (wr_fn)  functions <= wd;
    end
  end

  assign pending  = 1'b0;
  assign per_view = period;
  assign c1_view  = compare1;
  assign c2_view  = compare2;
  assign fn_view  = functions;
`endif

  // Read mux over offsets; committed values only, never staging bytes
  always_comb begin
    rd = 8'h00;
    case (off)
      4'h0: rd = per_view[7:0];
      4'h1: rd = per_view[15:8];
      4'h2: rd = {7'b0, en};
      4'h3: rd = c1_view[7:0];
      4'h4: rd = c1_view[15:8];
      4'h5: rd = c2_view[7:0];
      4'h6: rd = c2_view[15:8];
      4'h8: rd = cnt[7:0];
      4'h9: rd = snap_hi;
      4'hA: rd = prescale;
      4'hB: rd = {7'b0, upnotdown};
      4'hC: rd = {7'b0, pwm_en};
      4'hD: rd = fn_view;
      4'hE: rd = {7'b0, pending};
      default: rd = 8'h00;
    endcase
  end

endmodule

module pwm_regs_mc #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 read,
  input  logic                 write,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [7:0]           data_write,
  output logic [7:0]           data_read,
  input  logic [16*NUM_CH-1:0] counter_val,
  input  logic [NUM_CH-1:0]    update_evt,
  output logic [16*NUM_CH-1:0] period,
  output logic [16*NUM_CH-1:0] compare1,
  output logic [16*NUM_CH-1:0] compare2,
  output logic [8*NUM_CH-1:0]  functions,
  output logic [8*NUM_CH-1:0]  prescale,
  output logic [NUM_CH-1:0]    en,
  output logic [NUM_CH-1:0]    upnotdown,
  output logic [NUM_CH-1:0]    pwm_en,
  output logic [NUM_CH-1:0]    count_reset
);

  localparam int CW = ADDR_W - 4;

  logic [CW-1:0]             ch;
  logic [3:0]                off;
  logic [NUM_CH-1:0]         sel;
  logic [NUM_CH-1:0][7:0]    rd_ch;
  logic [7:0]                rd_mux;
  logic                      rd_only;

  assign ch      = addr[ADDR_W-1:4];
  assign off     = addr[3:0];
  // Write wins over a simultaneous read
  assign rd_only = read && !write;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      // Channel indices beyond NUM_CH match no instance: writes drop, reads give 0
      assign sel[c] = (ch == CW'(c));
      pwm_regs_ch u_ch (
        .clk         (clk),
        .rst_n       (rst_n),
        .we          (write && sel[c]),
        .re          (rd_only && sel[c]),
        .off         (off),
        .wd          (data_write),
        .cnt         (counter_val[16*c +: 16]),
        .upd_evt     (update_evt[c]),
        .rd          (rd_ch[c]),
        .period      (period[16*c +: 16]),
        .compare1    (compare1[16*c +: 16]),
        .compare2    (compare2[16*c +: 16]),
        .functions   (functions[8*c +: 8]),
        .prescale    (prescale[8*c +: 8]),
        .en          (en[c]),
        .upnotdown   (upnotdown[c]),
        .pwm_en      (pwm_en[c]),
        .count_reset (count_reset[c])
      );
    end
  endgenerate

  // Pick the addressed channel's read byte
  always_comb begin
    rd_mux = 8'h00;
    for (int i = 0; i < NUM_CH; i++)
      if (sel[i]) rd_mux = rd_ch[i];
  end

  // Registered read data, zero whenever there is no read-only cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_read <= 8'h00;
    else        data_read <= rd_only ? rd_mux : 8'h00;
  end

endmodule

// File: tb/tb_pwm_regs_mc.sv
// Directed bench for pwm_regs_mc (4 channels, 3-bit channel index so 4..7 are invalid).
module tb_pwm_regs_mc;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 7;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 read = 1'b0;
  logic                 write = 1'b0;
  logic [ADDR_W-1:0]    addr = '0;
  logic [7:0]           data_write = '0;
  logic [7:0]           data_read;
  logic [16*NUM_CH-1:0] counter_val = '0;
  logic [NUM_CH-1:0]    update_evt = '0;
  logic [16*NUM_CH-1:0] period, compare1, compare2;
  logic [8*NUM_CH-1:0]  functions, prescale;
  logic [NUM_CH-1:0]    en, upnotdown, pwm_en, count_reset;

  int checks = 0;
  int errors = 0;

  pwm_regs_mc #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
    .data_write(data_write), .data_read(data_read), .counter_val(counter_val),
    .update_evt(update_evt), .period(period), .compare1(compare1),
    .compare2(compare2), .functions(functions), .prescale(prescale), .en(en),
    .upnotdown(upnotdown), .pwm_en(pwm_en), .count_reset(count_reset)
  );

  always #5 clk = ~clk;

  task automatic do_write(input logic [2:0] c, input logic [3:0] o, input logic [7:0] d);
    @(negedge clk);
    addr = {c, o}; data_write = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] c, input logic [3:0] o, output logic [7:0] d);
    @(negedge clk);
    addr = {c, o}; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = data_read;
  endtask

  // In the shadow build, force the buffered commit to the outputs
  task automatic commit_sync(input logic [2:0] c);
`ifdef PWM_REGS_SHADOW_EN
    do_write(c, 4'hE, 8'h01);
`else
    @(negedge clk);
    addr = {c, 4'h0};
`endif
  endtask

  task automatic test_reset();
    logic [7:0] d;
    checks++;
    if ({period, compare1, compare2, functions, prescale, en, upnotdown, pwm_en, count_reset, data_read} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    rst_n = 1'b1;
    for (int o = 0; o < 16; o++) begin
      do_read(3'd0, 4'(o), d);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL reset_read off %0h: got %h, required 00", o, d); end
    end
  endtask

  task automatic test_mid_reset();
    do_write(3'd0, 4'h0, 8'h55);
    @(negedge clk); rst_n = 1'b0; #2; rst_n = 1'b1;
    do_write(3'd0, 4'h1, 8'h66);
    commit_sync(3'd0);
    checks++;
    if (period[15:0] !== 16'h6600) begin errors++; $display("FAIL mid_reset_stage: got %h, required 6600", period[15:0]); end
  endtask

  task automatic test_period_write();
    logic [7:0] d;
    do_write(3'd2, 4'h0, 8'h34);
    do_read(3'd2, 4'h0, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL period_staged_read: got %h, required 00", d); end
    do_write(3'd2, 4'h1, 8'h12);
`ifndef PWM_REGS_SHADOW_EN
    checks++;
    if (period[47:32] !== 16'h1234) begin errors++; $display("FAIL period_commit: got %h, required 1234", period[47:32]); end
`endif
    commit_sync(3'd2);
    checks++;
    if (period[47:32] !== 16'h1234) begin errors++; $display("FAIL period_active: got %h, required 1234", period[47:32]); end
    checks++;
    if (period[31:16] !== 16'h0000 || period[63:48] !== 16'h0000) begin
      errors++; $display("FAIL period_other_ch: got %h, required 0 in ch1/ch3", period);
    end
    do_read(3'd2, 4'h0, d);
    checks++;
    if (d !== 8'h34) begin errors++; $display("FAIL period_read_l: got %h, required 34", d); end
    do_read(3'd2, 4'h1, d);
    checks++;
    if (d !== 8'h12) begin errors++; $display("FAIL period_read_h: got %h, required 12", d); end
  endtask

  task automatic test_last_l_wins();
    do_write(3'd1, 4'h3, 8'h11);
    do_write(3'd1, 4'h3, 8'h22);
    do_write(3'd1, 4'h4, 8'h33);
    do_write(3'd1, 4'h6, 8'h77);
    commit_sync(3'd1);
    checks++;
    if (compare1[31:16] !== 16'h3322) begin errors++; $display("FAIL last_l_wins: got %h, required 3322", compare1[31:16]); end
    checks++;
    if (compare2[31:16] !== 16'h7700) begin errors++; $display("FAIL h_without_l: got %h, required 7700", compare2[31:16]); end
  endtask

  task automatic test_counter_snapshot();
    logic [7:0] d;
    counter_val[31:16] = 16'h00FF;
    do_read(3'd1, 4'h8, d);
    checks++;
    if (d !== 8'hFF) begin errors++; $display("FAIL cnt_read_l: got %h, required ff", d); end
    counter_val[31:16] = 16'h0100;
    do_read(3'd1, 4'h9, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL cnt_snapshot_h: got %h, required 00", d); end
    do_read(3'd1, 4'h8, d);
    do_read(3'd1, 4'h9, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL cnt_snapshot_h2: got %h, required 01", d); end
  endtask

  task automatic test_count_reset();
    logic [7:0] d;
    do_write(3'd3, 4'h7, 8'h01);
    checks++;
    if (count_reset !== 4'b1000) begin errors++; $display("FAIL count_reset_pulse: got %b, required 1000", count_reset); end
    @(negedge clk);
    checks++;
    if (count_reset !== 4'b0000) begin errors++; $display("FAIL count_reset_clear: got %b, required 0000", count_reset); end
    do_write(3'd3, 4'h7, 8'h00);
    checks++;
    if (count_reset !== 4'b0000) begin errors++; $display("FAIL count_reset_bit0_low: got %b, required 0000", count_reset); end
    do_read(3'd3, 4'h7, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL count_reset_read: got %h, required 00", d); end
  endtask

  task automatic test_byte_regs();
    logic [7:0] d;
    do_write(3'd0, 4'h2, 8'h03);
    checks++;
    if (en !== 4'b0001) begin errors++; $display("FAIL en_write: got %b, required 0001", en); end
    do_read(3'd0, 4'h2, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL en_read: got %h, required 01", d); end
    do_write(3'd1, 4'hA, 8'hA5);
    checks++;
    if (prescale !== 32'h0000A500) begin errors++; $display("FAIL prescale_write: got %h, required 0000a500", prescale); end
    do_write(3'd2, 4'hB, 8'hFF);
    do_write(3'd3, 4'hC, 8'h01);
    checks++;
    if (upnotdown !== 4'b0100 || pwm_en !== 4'b1000) begin
      errors++; $display("FAIL dir_pwm_en: got %b/%b, required 0100/1000", upnotdown, pwm_en);
    end
    do_write(3'd0, 4'hD, 8'hC3);
    commit_sync(3'd0);
    checks++;
    if (functions[7:0] !== 8'hC3) begin errors++; $display("FAIL functions: got %h, required c3", functions[7:0]); end
    do_read(3'd2, 4'hB, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL upnotdown_read: got %h, required 01", d); end
    @(negedge clk);
    checks++;
    if (data_read !== 8'h00) begin errors++; $display("FAIL idle_read_zero: got %h, required 00", data_read); end
  endtask

  task automatic test_rw_conflict();
    @(negedge clk);
    addr = {3'd0, 4'hA}; data_write = 8'h5A; write = 1'b1; read = 1'b1;
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    checks++;
    if (data_read !== 8'h00) begin errors++; $display("FAIL rw_conflict_read: got %h, required 00", data_read); end
    checks++;
    if (prescale[7:0] !== 8'h5A) begin errors++; $display("FAIL rw_conflict_write: got %h, required 5a", prescale[7:0]); end
  endtask

  task automatic test_invalid_ch();
    logic [7:0] d;
    do_write(3'd4, 4'hA, 8'hFF);
    do_write(3'd5, 4'h2, 8'h01);
    checks++;
    if (prescale !== 32'h0000A55A || en !== 4'b0001) begin
      errors++; $display("FAIL invalid_ch_write: got %h/%b, required 0000a55a/0001", prescale, en);
    end
    do_read(3'd4, 4'hA, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL invalid_ch_read: got %h, required 00", d); end
  endtask

`ifdef PWM_REGS_SHADOW_EN
  task automatic test_shadow();
    logic [7:0] d;
    do_write(3'd0, 4'h3, 8'h50);
    do_write(3'd0, 4'h4, 8'h00);
    checks++;
    if (compare1[15:0] !== 16'h0000) begin errors++; $display("FAIL shadow_hold: got %h, required 0000", compare1[15:0]); end
    do_read(3'd0, 4'hE, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL shadow_pending: got %h, required 01", d); end
    @(negedge clk); update_evt = 4'b0001;
    @(negedge clk); update_evt = 4'b0000;
    checks++;
    if (compare1[15:0] !== 16'h0050) begin errors++; $display("FAIL shadow_load: got %h, required 0050", compare1[15:0]); end
    do_read(3'd0, 4'hE, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL shadow_cleared: got %h, required 00", d); end
    // Commit colliding with the period boundary
    do_write(3'd0, 4'h0, 8'hAA);
    do_write(3'd0, 4'h1, 8'h00);
    do_write(3'd0, 4'h0, 8'hBB);
    @(negedge clk);
    addr = {3'd0, 4'h1}; data_write = 8'h00; write = 1'b1; update_evt = 4'b0001;
    @(negedge clk);
    write = 1'b0; update_evt = 4'b0000;
    checks++;
    if (period[15:0] !== 16'h00AA) begin errors++; $display("FAIL shadow_collide: got %h, required 00aa", period[15:0]); end
    do_read(3'd0, 4'hE, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL shadow_collide_pending: got %h, required 01", d); end
    @(negedge clk); update_evt = 4'b0001;
    @(negedge clk); update_evt = 4'b0000;
    checks++;
    if (period[15:0] !== 16'h00BB) begin errors++; $display("FAIL shadow_second_load: got %h, required 00bb", period[15:0]); end
  endtask
`else
  task automatic test_no_shadow();
    logic [7:0] d;
    do_write(3'd0, 4'hE, 8'h01);
    do_read(3'd0, 4'hE, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL status_no_shadow: got %h, required 00", d); end
    do_write(3'd0, 4'h3, 8'h50);
    do_write(3'd0, 4'h4, 8'h00);
    checks++;
    if (compare1[15:0] !== 16'h0050) begin errors++; $display("FAIL direct_commit: got %h, required 0050", compare1[15:0]); end
    @(negedge clk); update_evt = 4'b1111;
    @(negedge clk); update_evt = 4'b0000;
    checks++;
    if (compare1[15:0] !== 16'h0050 || period[47:32] !== 16'h1234) begin
      errors++; $display("FAIL update_evt_ignored: got %h/%h, required 0050/1234", compare1[15:0], period[47:32]);
    end
  endtask
`endif

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_mid_reset();
    test_period_write();
    test_last_l_wins();
    test_counter_snapshot();
    test_count_reset();
    test_byte_regs();
    test_rw_conflict();
    test_invalid_ch();
`ifdef PWM_REGS_SHADOW_EN
    test_shadow();
`else
    test_no_shadow();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
